// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank pattern, hex decode table, index width helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seg7_pkg;

  // All segments off (active-low bus).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Per-slot display phase of the scan multiplexer.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

  // Hex nibble to {a,b,c,d,e,f,g}, active-low. Identical to the counter stage.
  function automatic logic [6:0] hex_decode(input logic [3:0] hex);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Bits needed to index num_digits digits; never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 2) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Bundle between the value source and the scan multiplexer, plus the display pins.
// Latency: n/a (wires only).
// Backpressure: none; load is a fire-and-forget strobe.
//   value/dp_in/load/blank_lz : source -> mux (digit 0 is value[3:0])
//   seg7/dp/an/frame_done     : mux -> display pins and frame pulse
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [6:0]              seg7;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, dp_in, load, blank_lz,
    input  seg7, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, blank_lz,
    output seg7, dp, an, frame_done
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   nibble : 4-bit hex digit in
//   seg7   : {a,b,c,d,e,f,g} active-low out
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  assign seg7 = hex_decode(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed, double-buffered hex display driver with per-slot dead-time blanking.
// Latency: registered outputs; a load becomes visible at the next frame boundary.
// Backpressure: none; later loads in the same frame overwrite the shadow.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seg7_scan_mux_if (value, dp_in, load, blank_lz in;
//              seg7, dp, an, frame_done out)
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic            clk,
  input logic            rst,
  seg7_scan_mux_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  logic [CNT_W-1:0]      slot_cnt, slot_cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  digits_t               shadow_val, active_val, active_val_nxt;
  logic [NUM_DIGITS-1:0] shadow_dp, active_dp, active_dp_nxt;
  logic                  pending, pending_nxt;
  logic                  frame_wrap;
  slot_state_t           state, state_nxt;

  logic                  lz_seen;
  logic [NUM_DIGITS-1:0] lz_sup;
  logic [6:0]            dec_seg;
  logic [6:0]            seg7_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  frame_done_nxt;

  // Slot counter and digit index.
  always_comb begin
    slot_cnt_nxt = slot_cnt + 1'b1;
    idx_nxt      = idx;
    if (slot_cnt == CNT_LAST) begin
      slot_cnt_nxt = '0;
      idx_nxt      = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // The edge leaving the last slot of a frame lands on the next frame boundary.
  assign frame_wrap = (slot_cnt == CNT_LAST) && (idx == IDX_LAST);

  // Shadow -> active transfer only on the boundary so a frame never tears.
  // A load on the boundary edge itself goes straight to active.
  always_comb begin
    active_val_nxt = active_val;
    active_dp_nxt  = active_dp;
    pending_nxt    = pending;
    if (frame_wrap) begin
      pending_nxt = 1'b0;
      if (bus.load) begin
        active_val_nxt = bus.value;
        active_dp_nxt  = bus.dp_in;
      end else if (pending) begin
        active_val_nxt = shadow_val;
        active_dp_nxt  = shadow_dp;
      end
    end else if (bus.load) begin
      pending_nxt = 1'b1;
    end
  end

  // A digit is suppressed when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    lz_seen = 1'b0;
    lz_sup  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_seen   = lz_seen | (active_val_nxt[i] != 4'h0);
      lz_sup[i] = ~lz_seen;
    end
  end

  // Outputs are registered from next-state values so they line up with the counter.
  hex_to_seg7 u_dec (
    .nibble (active_val_nxt[idx_nxt]),
    .seg7   (dec_seg)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (slot_cnt_nxt == CNT_SHOW) state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_cnt_nxt == '0)       state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase

    seg7_nxt = SEG_BLANK;
    an_nxt   = '1;
    dp_nxt   = 1'b1;
    if (state_nxt == ST_SHOW) begin
      an_nxt[idx_nxt] = 1'b0;
      seg7_nxt        = (bus.blank_lz && lz_sup[idx_nxt]) ? SEG_BLANK : dec_seg;
      dp_nxt          = ~active_dp_nxt[idx_nxt];
    end

    frame_done_nxt = (slot_cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt       <= '0;
      idx            <= '0;
      state          <= ST_BLANK;
      shadow_val     <= '0;
      shadow_dp      <= '0;
      active_val     <= '0;
      active_dp      <= '0;
      pending        <= 1'b0;
      bus.seg7       <= SEG_BLANK;
      bus.dp         <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      slot_cnt   <= slot_cnt_nxt;
      idx        <= idx_nxt;
      state      <= state_nxt;
      active_val <= active_val_nxt;
      active_dp  <= active_dp_nxt;
      pending    <= pending_nxt;
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
      end
      bus.seg7       <= seg7_nxt;
      bus.dp         <= dp_nxt;
      bus.an         <= an_nxt;
      bus.frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboarded bench for seg7_scan_mux with a 4-digit, 8-cycle-slot, 2-cycle-blank setup.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_mux;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: cycle-position based, expected {an,seg7,dp,frame_done} per edge.
  int          cyc = 0;
  logic [15:0] m_shadow, m_act;
  logic [3:0]  m_shdp, m_actdp;
  bit          m_pend;
  logic [12:0] exp_q [$];

  always @(posedge clk) begin : model
    int          pos, dig, hi;
    logic [3:0]  nib;
    logic [12:0] e;
    if (rst) begin
      cyc      = 0;
      m_shadow = '0;
      m_shdp   = '0;
      m_act    = '0;
      m_actdp  = '0;
      m_pend   = 1'b0;
      e        = {4'hF, 7'h7F, 1'b1, 1'b0};
    end else begin
      cyc++;
      pos = cyc % (N * R);
      if (pos == 0) begin
        if (bus.load) begin
          m_act   = bus.value;
          m_actdp = bus.dp_in;
        end else if (m_pend) begin
          m_act   = m_shadow;
          m_actdp = m_shdp;
        end
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_shadow = bus.value;
        m_shdp   = bus.dp_in;
        m_pend   = 1'b1;
      end
      dig = pos / R;
      e   = {4'hF, 7'h7F, 1'b1, (pos == N * R - 1)};
      if ((pos % R) >= B) begin
        hi = 0;
        for (int i = 0; i < N; i++)
          if (((m_act >> (4 * i)) & 16'hF) != 16'h0) hi = i;
        nib      = 4'((m_act >> (4 * dig)) & 16'hF);
        e[12:9]  = ~(4'b0001 << dig);
        e[8:2]   = (bus.blank_lz && dig > hi) ? 7'h7F : SEG_TAB[nib];
        e[1]     = ~m_actdp[dig];
      end
    end
    exp_q.push_back(e);
  end

  bit          in_tear = 1'b0;
  bit          saw_a   = 1'b0;
  logic [12:0] mon_e;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq("cycle_out", {19'd0, bus.an, bus.seg7, bus.dp, bus.frame_done}, {19'd0, mon_e});
    end
    if (in_tear && bus.an != 4'hF && bus.seg7 == 7'b0001000) saw_a = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      tick();
      guard++;
    end
    if (cyc != n) check_eq("goto_bound", cyc, n);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic load_at(input int k, input logic [15:0] v, input logic [3:0] d);
    goto(k - 1);
    bus.value = v;
    bus.dp_in = d;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic spot(input int k, input string tag, input logic [3:0] an, input logic [6:0] seg);
    goto(k);
    check_eq({tag, "_an"}, bus.an, an);
    check_eq({tag, "_seg"}, bus.seg7, seg);
  endtask

  initial begin
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset with load held high: load must be ignored.
    bus.value = 16'hFFFF;
    bus.dp_in = 4'hF;
    bus.load  = 1'b1;
    do_reset(3);
    bus.load  = 1'b0;
    check_eq("rst_an",  bus.an, 4'hF);
    check_eq("rst_seg", bus.seg7, 7'h7F);
    check_eq("rst_dp",  bus.dp, 1'b1);
    check_eq("rst_fd",  bus.frame_done, 1'b0);
    spot(3, "rst_zero", 4'b1110, 7'b0000001);

    // Basic display.
    load_at(5, 16'h1234, 4'b0010);
    goto(30);
    check_eq("fd_30", bus.frame_done, 1'b0);
    goto(31);
    check_eq("fd_31", bus.frame_done, 1'b1);
    spot(34, "basic_d0", 4'b1110, 7'b1001100);
    check_eq("basic_d0_dp", bus.dp, 1'b1);
    spot(43, "basic_d1", 4'b1101, 7'b0000110);
    check_eq("basic_d1_dp", bus.dp, 1'b0);
    spot(48, "basic_gap48", 4'hF, 7'h7F);
    spot(57, "basic_gap57", 4'hF, 7'h7F);
    goto(60);

    // Tearing and last-write-wins.
    do_reset(1);
    in_tear = 1'b1;
    load_at(5, 16'h1234, 4'b0000);
    load_at(40, 16'hAAAA, 4'b0000);
    spot(44, "tear_keep", 4'b1101, 7'b0000110);
    load_at(50, 16'hBBBB, 4'b0000);
    spot(66, "tear_b0", 4'b1110, 7'b1100000);
    spot(92, "tear_b3", 4'b0111, 7'b1100000);
    goto(100);
    in_tear = 1'b0;
    check_eq("no_torn_a", saw_a, 1'b0);

    // Load coinciding with the frame boundary bypasses into active.
    do_reset(1);
    load_at(64, 16'hFFFF, 4'b0001);
    spot(66, "bypass", 4'b1110, 7'b0111000);
    check_eq("bypass_dp", bus.dp, 1'b0);
    goto(72);

    // Leading-zero suppression.
    bus.blank_lz = 1'b1;
    do_reset(1);
    load_at(3, 16'h0070, 4'b0000);
    spot(34, "lz_d0", 4'b1110, 7'b0000001);
    spot(42, "lz_d1", 4'b1101, 7'b0001111);
    spot(50, "lz_d2", 4'b1011, 7'h7F);
    spot(58, "lz_d3", 4'b0111, 7'h7F);
    load_at(70, 16'h0000, 4'b0000);
    spot(98, "lz0_d0", 4'b1110, 7'b0000001);
    spot(106, "lz0_d1", 4'b1101, 7'h7F);
    goto(128);
    bus.blank_lz = 1'b0;

    // Reset mid-frame discards a pending load.
    do_reset(1);
    load_at(44, 16'h5555, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_an",  bus.an, 4'hF);
    check_eq("midrst_seg", bus.seg7, 7'h7F);
    spot(3, "midrst_zero", 4'b1110, 7'b0000001);
    spot(34, "midrst_lost", 4'b1110, 7'b0000001);
    goto(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage for the 4-bit counter / seven-segment path.
- Takes NUM_DIGITS hex nibbles, time-multiplexes them onto one shared active-low segment bus, and drives active-low digit anodes.
- Inserts a dead-time blanking interval between digits to suppress ghosting.
- Double-buffers the displayed value so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot. Must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot during which all outputs are blanked. Must be at least 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset. Synchronous, active-high.
- value  in  4*NUM_DIGITS  hex digits. Digit 0 is value[3:0].
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- load  in  1  single-cycle strobe. Captures value and dp_in into the shadow register.
- blank_lz  in  1  leading-zero suppression enable. Sampled live.
- seg7  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low while showing.
- frame_done  out  1  one-cycle pulse on the last cycle of each full frame.

Behaviour:
- Timing reference: cycle n is the n-th rising edge after the last edge at which rst was sampled high.
- Reset values:
  - seg7=7'b1111111, dp=1, an=all ones, frame_done=0.
  - Shadow and active registers = 0. Digit index = 0. Slot counter = 0.
- All outputs are registered.
- Slot timing:
  - Slot counter runs 0..REFRESH_DIV-1, then wraps to 0 and advances the digit index.
  - The digit index wraps NUM_DIGITS-1 -> 0.
- Two-state FSM per slot:
  - BLANK, for slot_cnt < BLANK_CYCLES: an=all ones, seg7=1111111, dp=1.
  - SHOW, for the remaining cycles: an has a 0 only at the bit for the current digit index; seg7 = decode(active nibble[idx]); dp = ~active_dp[idx].
- Frame boundary: the cycle where slot_cnt=0 and idx=0. Digit d shows during cycles F + d*REFRESH_DIV + BLANK_CYCLES .. F + (d+1)*REFRESH_DIV - 1, where F is the frame start.
- Load and transfer:
  - load at cycle k writes the shadow and sets the pending flag.
  - At each frame boundary, if pending is set: active <= shadow, and pending clears.
  - A later load before the boundary overwrites the shadow (last write wins).
- Simultaneous load and frame boundary: the incoming value and dp_in bypass straight into the active register for that frame, and pending is cleared.
- load is ignored while rst is high.
- frame_done is asserted when idx=NUM_DIGITS-1 and slot_cnt=REFRESH_DIV-1.
- Leading-zero suppression (blank_lz=1):
  - Every digit above the highest nonzero digit of the active value shows seg7=1111111. Its anode still cycles normally; dp follows active_dp.
  - Digit 0 is never suppressed, so value 0 displays "0".
- Decode table (hex to seg7, active-low), matching the counter stage:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset mid-operation: the next edge forces all reset values, and any pending load is discarded. Timing restarts at cycle 0 after release.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK=7'b1111111.
  - The 16-entry hex decode table, as a constant function.
  - A digit-index width helper (clog2 of NUM_DIGITS).
- One natural sub-module: hex_to_seg7, a combinational nibble -> seg7 decoder. Shared with the counter stage so both encode identically.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, which gives a 32-cycle frame.
- Reset: hold rst high 3 cycles with load=1 -> seg7=1111111, an=1111, dp=1, frame_done=0. Active value = 0, so cycles 2..7 show an=1110, seg7=0000001.
- Basic display, blank_lz=0: load 16'h1234 with dp_in=4'b0010 at cycle 5.
  - Frame 0 shows all zeros. frame_done pulses at cycle 31.
  - Cycles 34..39: an=1110, seg7=1001100 ("4"), dp=1.
  - Cycles 42..47: an=1101, seg7=0000110 ("3"), dp=0.
  - Cycles 48,49 and 56,57: an=1111.
- Leading-zero suppression: load 16'h0070 with blank_lz=1.
  - Digit 0 = 0000001, digit 1 = 0001111.
  - Digits 2 and 3 = 1111111, with their anodes still asserted in turn.
  - Loading 16'h0000 then shows only digit 0 = 0000001.
- Tearing and last-write-wins: load 16'hAAAA at cycle 40, then 16'hBBBB at cycle 50.
  - Cycles 32..63 keep the prior value.
  - From cycle 66 every digit shows 1100000; 0001000 never appears.
- Simultaneous load at boundary: load 16'hFFFF exactly at cycle 64 -> cycles 66..71 show an=1110, seg7=0111000.
- Reset mid-frame: assert rst at cycle 45 for one cycle, with a load pending from cycle 44.
  - Next cycle: an=1111, seg7=1111111.
  - After release, cycles 2..7 show "0"; the pending value is lost.
